if_fetch_queue: RTL

//   Decoupled instruction-fetch front end: PC generator + in-order prefetch queue feeding ID.

---
 rtl/if_fetch_queue.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generator, credit-limited request issue and in-order prefetch queue.
// Optional statistics counters are enabled by defining IF_FETCH_QUEUE_STATS_EN.
module if_fetch_queue #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic        o_req_valid,
    output logic [31:0] o_req_addr,
    input  logic        i_req_ready,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_rdata,
    input  logic        i_rsp_err,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_fault,
    input  logic        i_inst_ready,
`ifdef IF_FETCH_QUEUE_STATS_EN
    output logic [31:0] o_stat_drop_cnt,
    output logic [31:0] o_stat_starve_cnt,
`endif
    output logic        o_busy
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic          r_halted;

    logic [31:0]   r_mem_data [QUEUE_DEPTH];
    logic [31:0]   r_mem_pc   [QUEUE_DEPTH];
    logic          r_mem_err  [QUEUE_DEPTH];

    logic [31:0]   w_redirect_pc;
    logic [SW-1:0] w_inflight;
    logic          w_fire;
    logic          w_rsp_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_unused_tgt;

    assign w_redirect_pc = {i_redirect_target[31:2], 2'b00};
    assign w_unused_tgt  = ^i_redirect_target[1:0];
    assign w_inflight    = {1'b0, r_count} + {1'b0, r_outstanding};

    // Credit check reserves a queue slot for every in-flight word, so pushes never overflow.
    // Gating with i_rst_n keeps the request deasserted while reset is held.
    assign o_req_valid = i_rst_n && !i_redirect && !r_halted
                         && (r_outstanding < CW'(MAX_OUTSTANDING))
                         && (w_inflight < SW'(QUEUE_DEPTH));
    assign o_req_addr  = r_pc;
    assign w_fire      = o_req_valid && i_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_rsp_ok = i_rsp_valid && (r_outstanding != '0);
    assign w_push   = w_rsp_ok && (r_drop_cnt == '0) && !i_redirect;
    assign w_pop    = o_inst_valid && i_inst_ready && !i_redirect;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_ADDR;
            r_rsp_pc      <= RESET_ADDR;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_rsp_ok);
            if (i_redirect) begin
                r_pc       <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_halted   <= 1'b0;
                r_drop_cnt <= r_outstanding - CW'(w_rsp_ok);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp_ok && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    if (i_rsp_err) begin
                        r_halted <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_rsp_rdata;
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
            r_mem_err[r_wr_ptr]  <= i_rsp_err;
        end
    end

    always_comb begin
        o_inst_valid = (r_count != '0);
        o_inst       = NOP;
        o_inst_pc    = '0;
        o_inst_fault = 1'b0;
        if (o_inst_valid) begin
            o_inst       = r_mem_data[r_rd_ptr];
            o_inst_pc    = r_mem_pc[r_rd_ptr];
            o_inst_fault = r_mem_err[r_rd_ptr];
        end
    end

    assign o_busy = (r_outstanding != '0);

`ifdef IF_FETCH_QUEUE_STATS_EN
    logic [31:0] r_stat_drop;
    logic [31:0] r_stat_starve;
    logic        w_discard;

    // Same-cycle response on a redirect is discarded along with the drop_cnt backlog.
    assign w_discard = w_rsp_ok && (i_redirect || (r_drop_cnt != '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_drop   <= '0;
            r_stat_starve <= '0;
        end else begin
            if (w_discard && (r_stat_drop != '1)) begin
                r_stat_drop <= r_stat_drop + 32'd1;
            end
            if ((r_count == '0) && !i_redirect && (r_stat_starve != '1)) begin
                r_stat_starve <= r_stat_starve + 32'd1;
            end
        end
    end

    assign o_stat_drop_cnt   = r_stat_drop;
    assign o_stat_starve_cnt = r_stat_starve;
`endif

endmodule
